// File: rtl/rx_cond_pkg.sv
// Shared constants, width helpers and parameter legality predicates for the
// rx_line_conditioner receive front end.
package rx_cond_pkg;

  // Level an idle UART line rests at; all line-level state resets to it.
  localparam logic IDLE_LEVEL = 1'b1;

  // Width of the glitch-filter counter for a given filter length.
  function automatic int unsigned filt_cnt_width(input int unsigned filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

  // Width of the saturating break-duration counter.
  function automatic int unsigned brk_cnt_width(input int unsigned break_cycles);
    return (break_cycles < 1) ? 1 : $clog2(break_cycles + 1);
  endfunction

  function automatic bit channels_ok(input int unsigned channels);
    return channels >= 1;
  endfunction

  function automatic bit sync_stages_ok(input int unsigned sync_stages);
    return (sync_stages >= 2) && (sync_stages <= 4);
  endfunction

  function automatic bit filter_cycles_ok(input int unsigned filter_cycles);
    return (filter_cycles >= 1) && (filter_cycles <= 255);
  endfunction

  function automatic bit break_cycles_ok(input int unsigned break_cycles);
    return break_cycles >= 1;
  endfunction

endpackage

// File: rtl/rx_cond_channel.sv
// One receive channel: pull-up resolution, synchroniser, consecutive-sample
// glitch filter (or bypass), registered edge strobes and, when
// RX_COND_BREAK_DETECT_EN is defined, a saturating break detector.
module rx_cond_channel
  import rx_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned BREAK_CYCLES  = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic line_driven,
  input  logic pullup_en,
  input  logic filt_en,
  output logic rx_out,
  output logic fall_edge,
  output logic rise_edge
`ifdef RX_COND_BREAK_DETECT_EN
  ,
  output logic break_det
`endif
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
    $error("rx_cond_channel: SYNC_STAGES must be in 2..4");
  end
  if (!filter_cycles_ok(FILTER_CYCLES)) begin : g_bad_filter
    $error("rx_cond_channel: FILTER_CYCLES must be in 1..255");
  end
  if (!break_cycles_ok(BREAK_CYCLES)) begin : g_bad_break
    $error("rx_cond_channel: BREAK_CYCLES must be at least 1");
  end

  localparam int unsigned FiltW = filt_cnt_width(FILTER_CYCLES);
  // Count value at which one more disagreeing sample flips the output.
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_CYCLES - 1);

  logic                   eff;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   rx_d, rx_q;
  logic [FiltW-1:0]       cnt_d, cnt_q;
  logic                   fall_d, fall_q;
  logic                   rise_d, rise_q;

  // An undriven line with its pull-up enabled reads high.
  assign eff      = pullup_en ? (serial_in | ~line_driven) : serial_in;
  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, idle-high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], eff};
    end
  end

  // Next output level and filter count; strobes derive from the new level.
  always_comb begin
    rx_d  = rx_q;
    cnt_d = '0;
    if (!filt_en) begin
      rx_d = sync_lvl;
    end else if (sync_lvl != rx_q) begin
      if (cnt_q == FiltLast) begin
        rx_d = sync_lvl;
      end else begin
        cnt_d = cnt_q + FiltW'(1);
      end
    end
    fall_d = rx_q & ~rx_d;
    rise_d = ~rx_q & rx_d;
  end

  // Output level, filter counter and edge strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q   <= IDLE_LEVEL;
      cnt_q  <= '0;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign rx_out    = rx_q;
  assign fall_edge = fall_q;
  assign rise_edge = rise_q;

`ifdef RX_COND_BREAK_DETECT_EN
  localparam int unsigned BrkW = brk_cnt_width(BREAK_CYCLES);
  localparam logic [BrkW-1:0] BrkMax = BrkW'(BREAK_CYCLES);

  logic [BrkW-1:0] brk_cnt_d, brk_cnt_q;
  logic            brk_d, brk_q;

  // Count low cycles, saturating; flag holds until the line goes high again.
  always_comb begin
    brk_cnt_d = brk_cnt_q;
    if (rx_d) begin
      brk_cnt_d = '0;
    end else if (!rx_q && (brk_cnt_q != BrkMax)) begin
      brk_cnt_d = brk_cnt_q + BrkW'(1);
    end
    brk_d = ~rx_d & (brk_cnt_d == BrkMax);
  end

  // Break counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_cnt_q <= '0;
      brk_q     <= 1'b0;
    end else begin
      brk_cnt_q <= brk_cnt_d;
      brk_q     <= brk_d;
    end
  end

  assign break_det = brk_q;
`endif

endmodule

// File: rtl/rx_line_conditioner.sv
// Multi-channel UART receive-line conditioner. Each channel is an independent
// rx_cond_channel; filt_en is shared. Defining RX_COND_BREAK_DETECT_EN adds
// the break_det output and per-channel break counters.
module rx_line_conditioner
  import rx_cond_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned BREAK_CYCLES  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] serial_in,
  input  logic [CHANNELS-1:0] line_driven,
  input  logic [CHANNELS-1:0] pullup_en,
  input  logic                filt_en,
  output logic [CHANNELS-1:0] rx_out,
  output logic [CHANNELS-1:0] fall_edge,
  output logic [CHANNELS-1:0] rise_edge
`ifdef RX_COND_BREAK_DETECT_EN
  ,
  output logic [CHANNELS-1:0] break_det
`endif
);

  if (!channels_ok(CHANNELS)) begin : g_bad_channels
    $error("rx_line_conditioner: CHANNELS must be at least 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    rx_cond_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .BREAK_CYCLES (BREAK_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .serial_in  (serial_in[i]),
      .line_driven(line_driven[i]),
      .pullup_en  (pullup_en[i]),
      .filt_en    (filt_en),
      .rx_out     (rx_out[i]),
      .fall_edge  (fall_edge[i]),
      .rise_edge  (rise_edge[i])
`ifdef RX_COND_BREAK_DETECT_EN
      ,
      .break_det  (break_det[i])
`endif
    );
  end

endmodule
